// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//   Parameterised register file: one synchronous write port, three
//   asynchronous read ports, and a hardware clear sequencer that zeroes the
//   whole array one register per clock.
//
// Parameters
//   DATA_W   width of each register in bits
//   ADDR_W   address width; depth is 2**ADDR_W
//   ZERO_REG when non-zero, register 0 always reads 0 and writes to it are
//            silently discarded
//
// Ports
//   CLK                   clock, all state changes on its rising edge
//   RESET_N               asynchronous active-low reset
//   RegWrite              write enable
//   waddr / writedata     write address / data
//   raddr_a/_b/_c         read addresses
//   A / B / C             combinational read data
//   clr_req               start a clear sequence (honoured only when idle)
//   busy                  high while the clear sequence runs
//   clr_done              one-cycle pulse when the clear sequence finishes
//   wr_drop               one-cycle pulse after a write rejected by a clear
//
// Build option
//   REGFILE_BYPASS_EN     when defined, an accepted write is forwarded to any
//                         read port addressing the same register in the same
//                         cycle (never for register 0 when ZERO_REG is set).
// ---------------------------------------------------------------------------
module regfile_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] writedata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic [ADDR_W-1:0] raddr_c,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] C,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              wr_drop
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam bit          ZR    = (ZERO_REG != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_en;
  logic              clr_start;
  logic              clr_last;

  // -------------------------------------------------------------------------
  // Clear sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    clr_start = 1'b0;
    // The last address is all ones, so the counter wraps to 0 on the same
    // edge that leaves CLEAR; no extra cycle is spent.
    clr_last  = (clr_cnt == '1);
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx  = CLEAR;
          clr_start = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    busy     = (state == CLEAR);
    clr_done = (state == DONE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      clr_cnt <= '0;
    end else if (clr_start) begin
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Write path
  // -------------------------------------------------------------------------
  // Writes land only when idle; a write to register 0 with ZERO_REG set is
  // discarded without flagging wr_drop.
  always_comb begin
    wr_en = RegWrite && (state == IDLE) && !(ZR && (waddr == '0));
  end

  // Rejection is reported on the cycle after the offending edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= RegWrite && (state != IDLE);
    end
  end

  // A write and a clear start may share an IDLE edge: the write lands now and
  // the sweep begins on the next edge, so the cleared value wins.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[waddr] <= writedata;
      end
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] d;
    if (ZR && (ra == '0)) begin
      d = '0;
    end else begin
      d = mem[ra];
`ifdef REGFILE_BYPASS_EN
      // wr_en already excludes register 0 under ZERO_REG and non-idle states.
      if (wr_en && (waddr == ra)) begin
        d = writedata;
      end
`endif
    end
    return d;
  endfunction

  always_comb begin
    A = read_port(raddr_a);
    B = read_port(raddr_b);
    C = read_port(raddr_c);
  end

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic              CLK;
  logic              RESET_N;
  logic              RegWrite;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] writedata;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [ADDR_W-1:0] raddr_c;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [DATA_W-1:0] C;
  logic              clr_req;
  logic              busy;
  logic              clr_done;
  logic              wr_drop;

  int vectors;
  int miscompares;

  regfile_param #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(1)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .RegWrite (RegWrite),
    .waddr    (waddr),
    .writedata(writedata),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .raddr_c  (raddr_c),
    .A        (A),
    .B        (B),
    .C        (C),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .wr_drop  (wr_drop)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    RegWrite  = 1'b1;
    waddr     = a;
    writedata = d;
    tick();
    RegWrite  = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    #3;
    raddr_a = 4'd0; raddr_b = 4'd5; raddr_c = 4'd15;
    #1;
    vectors++;
    if ({busy, clr_done, wr_drop} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got busy/clr_done/wr_drop=%b expected 000", {busy, clr_done, wr_drop});
    end
    vectors++;
    if ({A, B, C} !== 48'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got A=%h B=%h C=%h expected 0000", A, B, C);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    // first edge after reset release must accept the write
    wr(4'd6, 16'h0066);
    raddr_a = 4'd6;
    #1;
    vectors++;
    if (A !== 16'h0066) begin
      miscompares++;
      $display("FAIL first_write: got A=%h expected 0066", A);
    end
  endtask

  task automatic test_zero_reg();
    wr(4'd0, 16'h000F);
    raddr_a = 4'd0;
    #1;
    vectors++;
    if (A !== 16'h0000) begin
      miscompares++;
      $display("FAIL zero_reg_read: got A=%h expected 0000", A);
    end
    vectors++;
    if (wr_drop !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_reg_wr_drop: got %b expected 0", wr_drop);
    end
  endtask

  task automatic test_write_read();
    wr(4'd1, 16'h00F0);
    wr(4'd2, 16'h0F00);
    raddr_a = 4'd0; raddr_b = 4'd1; raddr_c = 4'd2;
    #1;
    vectors++;
    if (A !== 16'h0000 || B !== 16'h00F0 || C !== 16'h0F00) begin
      miscompares++;
      $display("FAIL write_read: got A=%h B=%h C=%h expected 0000 00f0 0f00", A, B, C);
    end
  endtask

  task automatic test_same_addr();
    wr(4'd15, 16'hFFFF);
    raddr_a = 4'd15; raddr_b = 4'd15; raddr_c = 4'd15;
    #1;
    vectors++;
    if (A !== 16'hFFFF || B !== 16'hFFFF || C !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL same_addr: got A=%h B=%h C=%h expected ffff", A, B, C);
    end
  endtask

  task automatic test_clear();
    int busy_cnt;
    int done_cnt;
    int drop_cnt;
    bit finished;
    logic [DATA_W-1:0] exp;
    for (int i = 1; i < 16; i++) begin
      exp = 16'h1000 + 16'(i);
      wr(4'(i), exp);
    end
    busy_cnt = 0; done_cnt = 0; drop_cnt = 0; finished = 1'b0;
    // clr_req held high through CLEAR and DONE: it must be ignored there
    clr_req = 1'b1;
    for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
      tick();
      if (busy) busy_cnt++;
      if (clr_done) done_cnt++;
      if (wr_drop) drop_cnt++;
      if (busy_cnt == 4 && busy) RegWrite = 1'b0;
      if (busy_cnt == 3 && busy) begin
        RegWrite = 1'b1; waddr = 4'd3; writedata = 16'hABCD;
      end
      if (busy_cnt == 5 && busy) begin
        // counter is 4 here: addresses 0..3 cleared, 4 and up intact
        raddr_a = 4'd3; raddr_b = 4'd4; raddr_c = 4'd15;
        #1;
        vectors++;
        if (A !== 16'h0000 || B !== 16'h1004 || C !== 16'h100F) begin
          miscompares++;
          $display("FAIL partial_clear: got A=%h B=%h C=%h expected 0000 1004 100f", A, B, C);
        end
      end
      if (done_cnt > 0 && !busy && !clr_done) finished = 1'b1;
    end
    clr_req  = 1'b0;
    RegWrite = 1'b0;
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL clear_timeout: sequence did not return to idle within 40 cycles");
    end
    vectors++;
    if (busy_cnt != 16) begin
      miscompares++;
      $display("FAIL busy_cycles: got %0d expected 16", busy_cnt);
    end
    vectors++;
    if (done_cnt != 1) begin
      miscompares++;
      $display("FAIL clr_done_cycles: got %0d expected 1", done_cnt);
    end
    vectors++;
    if (drop_cnt != 1) begin
      miscompares++;
      $display("FAIL wr_drop_pulses: got %0d expected 1", drop_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      raddr_a = 4'(i);
      #1;
      vectors++;
      if (A !== 16'h0000) begin
        miscompares++;
        $display("FAIL cleared_reg[%0d]: got %h expected 0000", i, A);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int done_seen;
    for (int i = 1; i < 16; i++) wr(4'(i), 16'h2000 + 16'(i));
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    // now in the 1st CLEAR cycle; advance to the 5th
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_clear_busy: got %b expected 1", busy);
    end
    RESET_N = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || clr_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_flags: got busy=%b clr_done=%b expected 0 0", busy, clr_done);
    end
    for (int i = 0; i < 16; i++) begin
      raddr_b = 4'(i);
      #1;
      vectors++;
      if (B !== 16'h0000) begin
        miscompares++;
        $display("FAIL abort_reg[%0d]: got %h expected 0000", i, B);
      end
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (clr_done || busy) done_seen++;
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d busy/done cycles expected 0", done_seen);
    end
  endtask

  task automatic test_write_clear_same_edge();
    int guard;
    RegWrite = 1'b1; waddr = 4'd7; writedata = 16'h7777; clr_req = 1'b1;
    tick();
    RegWrite = 1'b0; clr_req = 1'b0;
    raddr_c = 4'd7;
    #1;
    vectors++;
    if (busy !== 1'b1 || C !== 16'h7777) begin
      miscompares++;
      $display("FAIL write_then_clear_start: got busy=%b C=%h expected 1 7777", busy, C);
    end
    guard = 0;
    while (!clr_done && guard < 40) begin
      tick();
      guard++;
    end
    tick();
    vectors++;
    if (C !== 16'h0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL write_then_clear_end: got C=%h busy=%b expected 0000 0", C, busy);
    end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] exp_same;
    wr(4'd5, 16'h5555);
    raddr_a = 4'd5; raddr_b = 4'd0;
    RegWrite = 1'b1; waddr = 4'd5; writedata = 16'h1234;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_same = 16'h1234;
`else
    exp_same = 16'h5555;
`endif
    vectors++;
    if (A !== exp_same) begin
      miscompares++;
      $display("FAIL same_cycle_read: got A=%h expected %h", A, exp_same);
    end
    tick();
    RegWrite = 1'b0;
    vectors++;
    if (A !== 16'h1234) begin
      miscompares++;
      $display("FAIL after_edge_read: got A=%h expected 1234", A);
    end
    // register 0 is never forwarded
    RegWrite = 1'b1; waddr = 4'd0; writedata = 16'hBEEF;
    #1;
    vectors++;
    if (B !== 16'h0000) begin
      miscompares++;
      $display("FAIL zero_reg_bypass: got B=%h expected 0000", B);
    end
    tick();
    RegWrite = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    RESET_N = 1'b0; RegWrite = 1'b0; waddr = '0; writedata = '0;
    raddr_a = '0; raddr_b = '0; raddr_c = '0; clr_req = 1'b0;
    test_reset();
    test_zero_reg();
    test_write_read();
    test_same_addr();
    test_clear();
    test_reset_mid_clear();
    test_write_clear_same_edge();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, meaning the width of each register in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 4, meaning the address width, so depth is DEPTH = 2^ADDR_W.
REQ-003 The module SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when set to 1.
REQ-004 The module SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port RESET_N  input  1  reset, asynchronous and active-low.
REQ-006 The module SHALL have port RegWrite  input  1  write enable, sampled on the rising edge of CLK.
REQ-007 The module SHALL have port waddr  input  ADDR_W  write address.
REQ-008 The module SHALL have port writedata  input  DATA_W  write data.
REQ-009 The module SHALL have ports raddr_a, raddr_b, raddr_c  input  ADDR_W  read addresses for ports A, B and C.
REQ-010 The module SHALL have ports A, B, C  output  DATA_W  read data, combinational from the matching raddr.
REQ-011 The module SHALL have port clr_req  input  1  request to clear every register.
REQ-012 The module SHALL have port busy  output  1  high while a clear sequence is running.
REQ-013 The module SHALL have port clr_done  output  1  one-cycle pulse when a clear sequence completes.
REQ-014 The module SHALL have port wr_drop  output  1  one-cycle pulse when a write is rejected.

Function
REQ-015 Reads SHALL be asynchronous: A = reg[raddr_a], B = reg[raddr_b], C = reg[raddr_c], with no clock latency.
REQ-016 All three read ports MAY address the same register at once, and each SHALL return that register's value.
REQ-017 When state is IDLE and RegWrite=1 at a rising edge, reg[waddr] SHALL take writedata, and the new value SHALL be visible on reads after that edge.
REQ-018 If ZERO_REG=1, register 0 SHALL always read 0, and a write to address 0 SHALL be discarded silently, with wr_drop staying low.
REQ-019 The clear FSM SHALL have states IDLE, CLEAR and DONE.
REQ-020 IDLE -> CLEAR SHALL occur when clr_req=1 at a rising edge; this also loads clr_cnt=0.
REQ-021 In CLEAR, each rising edge SHALL set reg[clr_cnt] to 0 and increment clr_cnt.
REQ-022 After the edge that clears DEPTH-1, the FSM SHALL go to DONE, so CLEAR lasts exactly DEPTH cycles.
REQ-023 DONE -> IDLE SHALL be unconditional after one cycle.
REQ-024 busy SHALL equal (state==CLEAR).
REQ-025 clr_done SHALL equal (state==DONE).
REQ-026 clr_req SHALL be ignored while in CLEAR or DONE.
REQ-027 A RegWrite=1 while in CLEAR or DONE SHALL NOT modify any register and SHALL assert wr_drop on the following cycle.
REQ-028 During CLEAR, reads SHALL return current contents, which are partially cleared: zero for addresses below clr_cnt and prior data at or above it.
REQ-029 If clr_req and RegWrite are both 1 at the same IDLE edge, the write SHALL complete and then the clear SHALL start; the cleared result wins.
REQ-030 clr_cnt SHALL be ADDR_W bits wide and SHALL wrap from DEPTH-1 to 0 with no extra cycle.

Reset
REQ-031 While RESET_N=0, asynchronously, all registers SHALL be 0, state SHALL be IDLE, clr_cnt SHALL be 0, and busy, clr_done and wr_drop SHALL be 0.
REQ-032 A reset asserted mid-CLEAR SHALL abort the sequence immediately, and clr_done SHALL NOT pulse.
REQ-033 The first write SHALL be accepted at the first rising edge after RESET_N rises.

Configuration
REQ-034 With macro REGFILE_BYPASS_EN defined, when state is IDLE and RegWrite=1 with waddr equal to a read address, that read port SHALL return writedata combinationally in the same cycle; this does not apply to address 0 when ZERO_REG=1.
REQ-035 Without REGFILE_BYPASS_EN, read ports SHALL return stored contents only, and a same-cycle read SHALL see the old value.

Verification
REQ-036 Reset, then write 0x000F to addr 0, then read A at addr 0 -> A=0x0000 and wr_drop=0.
REQ-037 Write 0x00F0 to addr 1 and 0x0F00 to addr 2, then read A=0, B=1, C=2 -> A=0x0000, B=0x00F0, C=0x0F00.
REQ-038 Write 0xFFFF to addr 15, then set raddr_a=raddr_b=raddr_c=15 -> A=B=C=0xFFFF.
REQ-039 Fill addrs 1..15 with nonzero data, pulse clr_req -> busy high for exactly 16 cycles, clr_done high for 1 cycle, then all reads return 0x0000; a RegWrite issued to addr 3 during busy -> wr_drop pulses and addr 3 reads 0x0000.
REQ-040 Assert reset at the 5th cycle of CLEAR -> busy=0 immediately, clr_done never pulses, and all registers read 0.
REQ-041 Write 0x1234 to addr 5 while raddr_a=5 -> A=0x1234 in the same cycle with REGFILE_BYPASS_EN defined, and A=old value until the edge without it.
